dual_port_ram_param: RTL and testbench

- Parametrised synchronous true dual-port RAM; next generation of the team's single-port 8x256 memory.
- Two independent read/write ports (A, B) on one clock, with byte-lane write enables and a configurable read pipeline (1 or 2 cycles).
- Defined read-during-write semantics, write-collision detection and out-of-range address flagging.
- Used as a shared buffer between two bus agents in the testbench DUT.

---
 rtl/dual_port_ram_pkg.sv | 24 ++
 rtl/dual_port_ram_param_read_pipe.sv | 59 +++++
 rtl/dual_port_ram_param.sv | 135 +++++++++++++
 tb/tb_dual_port_ram_param.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/dual_port_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dual_port_ram_pkg
// Brief   : Shared types, constants and lane-merge helper for dual_port_ram_param
// Rev     : 1.0
// ============================================================================
package dual_port_ram_pkg;

  typedef enum logic {
    RDW_OLD = 1'b0,
    RDW_NEW = 1'b1
  } rdw_mode_e;

  localparam int MAX_READ_LATENCY = 2;

  // Applied once per byte lane; callers iterate over the lanes of a word.
  function automatic logic [7:0] byte_merge(input logic [7:0] old_byte,
                                            input logic [7:0] new_byte,
                                            input logic       byte_en);
    return byte_en ? new_byte : old_byte;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dual_port_ram_param_read_pipe.sv
`default_nettype none
// ============================================================================
// Module  : ram_read_pipe
// Brief   : Read-data register chain (1 or 2 stages) with valid tracking
// Rev     : 1.0
// ============================================================================
module ram_read_pipe
  import dual_port_ram_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  issue,
  input  logic [DATA_WIDTH-1:0] issue_data,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid
);

  logic [DATA_WIDTH-1:0] r_stage1_data;
  logic                  r_stage1_valid;

  // Non-read cycles load zero so data_out is 0 whenever valid is low.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stage1_data  <= '0;
      r_stage1_valid <= 1'b0;
    end else begin
      r_stage1_data  <= issue ? issue_data : '0;
      r_stage1_valid <= issue;
    end
  end

  generate
    if (READ_LATENCY >= MAX_READ_LATENCY) begin : g_lat2
      logic [DATA_WIDTH-1:0] r_stage2_data;
      logic                  r_stage2_valid;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          r_stage2_data  <= '0;
          r_stage2_valid <= 1'b0;
        end else begin
          r_stage2_data  <= r_stage1_data;
          r_stage2_valid <= r_stage1_valid;
        end
      end

      assign data_out = r_stage2_data;
      assign valid    = r_stage2_valid;
    end else begin : g_lat1
      assign data_out = r_stage1_data;
      assign valid    = r_stage1_valid;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/dual_port_ram_param.sv
`default_nettype none
// ============================================================================
// Module  : dual_port_ram_param
// Brief   : Parametrised true dual-port RAM with byte enables, RDW and collision
// Rev     : 1.0
// ============================================================================
module dual_port_ram_param
  import dual_port_ram_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 8,
  parameter int DEPTH        = 256,
  parameter int READ_LATENCY = 1,
  parameter int RDW_MODE     = 0
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    a_enable,
  input  logic                    a_write,
  input  logic [ADDR_WIDTH-1:0]   a_address,
  input  logic [DATA_WIDTH-1:0]   a_data_in,
  input  logic [DATA_WIDTH/8-1:0] a_byte_en,
  output logic [DATA_WIDTH-1:0]   a_data_out,
  output logic                    a_valid,
  input  logic                    b_enable,
  input  logic                    b_write,
  input  logic [ADDR_WIDTH-1:0]   b_address,
  input  logic [DATA_WIDTH-1:0]   b_data_in,
  input  logic [DATA_WIDTH/8-1:0] b_byte_en,
  output logic [DATA_WIDTH-1:0]   b_data_out,
  output logic                    b_valid,
  output logic                    collision,
  output logic [1:0]              addr_err
);

  localparam int                 c_lanes = DATA_WIDTH / 8;
  localparam int                 c_idx_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] c_depth = (ADDR_WIDTH + 1)'(DEPTH);
  localparam rdw_mode_e          c_rdw   = (RDW_MODE != 0) ? RDW_NEW : RDW_OLD;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_a_in_range, w_b_in_range;
  logic                  w_a_wr, w_b_wr, w_a_rd, w_b_rd;
  logic                  w_same_addr, w_coll;
  logic [c_idx_w-1:0]    w_a_idx, w_b_idx;
  logic [DATA_WIDTH-1:0] w_a_old, w_b_old;
  logic [DATA_WIDTH-1:0] w_a_word, w_b_word, w_coll_word;
  logic [DATA_WIDTH-1:0] w_a_rd_data, w_b_rd_data;
  logic                  r_collision;
  logic [1:0]            r_addr_err;

  assign w_a_in_range = ({1'b0, a_address} < c_depth);
  assign w_b_in_range = ({1'b0, b_address} < c_depth);
  assign w_a_wr       = a_enable & a_write & w_a_in_range;
  assign w_b_wr       = b_enable & b_write & w_b_in_range;
  assign w_a_rd       = a_enable & ~a_write;
  assign w_b_rd       = b_enable & ~b_write;
  assign w_same_addr  = (a_address == b_address);
  assign w_coll       = w_a_wr & w_b_wr & w_same_addr;
  assign w_a_idx      = a_address[c_idx_w-1:0];
  assign w_b_idx      = b_address[c_idx_w-1:0];
  assign w_a_old      = r_mem[w_a_idx];
  assign w_b_old      = r_mem[w_b_idx];

  // On a collision port A is layered over port B, so A owns overlapping lanes.
  generate
    for (genvar i = 0; i < c_lanes; i++) begin : g_lane
      assign w_a_word[8*i +: 8]    = byte_merge(w_a_old[8*i +: 8], a_data_in[8*i +: 8], a_byte_en[i]);
      assign w_b_word[8*i +: 8]    = byte_merge(w_b_old[8*i +: 8], b_data_in[8*i +: 8], b_byte_en[i]);
      assign w_coll_word[8*i +: 8] = byte_merge(w_b_word[8*i +: 8], a_data_in[8*i +: 8], a_byte_en[i]);
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (w_coll) begin
      r_mem[w_a_idx] <= w_coll_word;
    end else begin
      if (w_a_wr) r_mem[w_a_idx] <= w_a_word;
      if (w_b_wr) r_mem[w_b_idx] <= w_b_word;
    end
  end

  always_comb begin
    w_a_rd_data = '0;
    w_b_rd_data = '0;
    if (w_a_in_range) begin
      w_a_rd_data = w_a_old;
      if ((c_rdw == RDW_NEW) && w_b_wr && w_same_addr) w_a_rd_data = w_b_word;
    end
    if (w_b_in_range) begin
      w_b_rd_data = w_b_old;
      if ((c_rdw == RDW_NEW) && w_a_wr && w_same_addr) w_b_rd_data = w_a_word;
    end
  end

  ram_read_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_pipe_a (
    .clock     (clock),
    .reset_n   (reset_n),
    .issue     (w_a_rd),
    .issue_data(w_a_rd_data),
    .data_out  (a_data_out),
    .valid     (a_valid)
  );

  ram_read_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_pipe_b (
    .clock     (clock),
    .reset_n   (reset_n),
    .issue     (w_b_rd),
    .issue_data(w_b_rd_data),
    .data_out  (b_data_out),
    .valid     (b_valid)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_collision <= 1'b0;
      r_addr_err  <= 2'b00;
    end else begin
      r_collision <= w_coll;
      r_addr_err  <= {b_enable & ~w_b_in_range, a_enable & ~w_a_in_range};
    end
  end

  assign collision = r_collision;
  assign addr_err  = r_addr_err;

endmodule
`default_nettype wire

// File: tb/tb_dual_port_ram_param.sv
`default_nettype none
// ============================================================================
// Module  : tb_dual_port_ram_param
// Brief   : Directed bench; dut0 = 1-cycle/old-data/DEPTH 200, dut1 = 2-cycle/new-data/DEPTH 256
// Rev     : 1.0
// ============================================================================
module tb_dual_port_ram_param;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        a_enable, a_write, b_enable, b_write;
  logic [7:0]  a_address, b_address;
  logic [31:0] a_data_in, b_data_in;
  logic [3:0]  a_byte_en, b_byte_en;

  logic [31:0] a_data_out0, b_data_out0, a_data_out1, b_data_out1;
  logic        a_valid0, b_valid0, a_valid1, b_valid1;
  logic        collision0, collision1;
  logic [1:0]  addr_err0, addr_err1;

  int tests  = 0;
  int failed = 0;

  always #5 clock = ~clock;

  dual_port_ram_param #(
    .DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(200), .READ_LATENCY(1), .RDW_MODE(0)
  ) dut0 (
    .clock(clock), .reset_n(reset_n),
    .a_enable(a_enable), .a_write(a_write), .a_address(a_address),
    .a_data_in(a_data_in), .a_byte_en(a_byte_en),
    .a_data_out(a_data_out0), .a_valid(a_valid0),
    .b_enable(b_enable), .b_write(b_write), .b_address(b_address),
    .b_data_in(b_data_in), .b_byte_en(b_byte_en),
    .b_data_out(b_data_out0), .b_valid(b_valid0),
    .collision(collision0), .addr_err(addr_err0)
  );

  dual_port_ram_param #(
    .DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(256), .READ_LATENCY(2), .RDW_MODE(1)
  ) dut1 (
    .clock(clock), .reset_n(reset_n),
    .a_enable(a_enable), .a_write(a_write), .a_address(a_address),
    .a_data_in(a_data_in), .a_byte_en(a_byte_en),
    .a_data_out(a_data_out1), .a_valid(a_valid1),
    .b_enable(b_enable), .b_write(b_write), .b_address(b_address),
    .b_data_in(b_data_in), .b_byte_en(b_byte_en),
    .b_data_out(b_data_out1), .b_valid(b_valid1),
    .collision(collision1), .addr_err(addr_err1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic port_a(input logic en, input logic wr, input logic [7:0] addr,
                        input logic [31:0] data, input logic [3:0] be);
    a_enable = en; a_write = wr; a_address = addr; a_data_in = data; a_byte_en = be;
  endtask

  task automatic port_b(input logic en, input logic wr, input logic [7:0] addr,
                        input logic [31:0] data, input logic [3:0] be);
    b_enable = en; b_write = wr; b_address = addr; b_data_in = data; b_byte_en = be;
  endtask

  task automatic idle();
    port_a(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    port_b(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    repeat (3) step();
    check("rst_a_data0", a_data_out0, 32'h0);
    check("rst_flags0", {29'h0, a_valid0, b_valid0, collision0}, 32'h0);
    check("rst_err0", {30'h0, addr_err0}, 32'h0);
    check("rst_a_data1", a_data_out1, 32'h0);
    check("rst_flags1", {29'h0, a_valid1, b_valid1, collision1}, 32'h0);
    reset_n = 1'b1;

    // Basic write then read with latency check on both configurations
    port_a(1'b1, 1'b1, 8'h10, 32'h000000A5, 4'hF);
    step();
    check("wr_no_valid0", {31'h0, a_valid0}, 32'h0);
    port_a(1'b1, 1'b0, 8'h10, 32'h0, 4'h0);
    step();
    check("rd_data0", a_data_out0, 32'h000000A5);
    check("rd_valid0", {31'h0, a_valid0}, 32'h1);
    check("rd_early_valid1", {31'h0, a_valid1}, 32'h0);
    check("rd_early_data1", a_data_out1, 32'h0);
    idle();
    step();
    check("rd_drop_valid0", {31'h0, a_valid0}, 32'h0);
    check("rd_drop_data0", a_data_out0, 32'h0);
    check("rd_data1", a_data_out1, 32'h000000A5);
    check("rd_valid1", {31'h0, a_valid1}, 32'h1);
    step();
    check("rd_drop_valid1", {31'h0, a_valid1}, 32'h0);

    // Byte-lane merge
    port_a(1'b1, 1'b1, 8'h03, 32'h11223344, 4'hF);
    step();
    port_a(1'b1, 1'b1, 8'h03, 32'hAABBCCDD, 4'b0101);
    step();
    port_a(1'b1, 1'b0, 8'h03, 32'h0, 4'h0);
    step();
    check("be_merge0", a_data_out0, 32'h11BB33DD);
    idle();
    step();
    check("be_merge1", a_data_out1, 32'h11BB33DD);

    // Write/write collision with partial lane overlap
    port_a(1'b1, 1'b1, 8'h20, 32'h99999999, 4'hF);
    step();
    port_a(1'b1, 1'b1, 8'h20, 32'h11111155, 4'b0011);
    port_b(1'b1, 1'b1, 8'h20, 32'h66666666, 4'b0101);
    step();
    check("coll_pulse0", {31'h0, collision0}, 32'h1);
    check("coll_pulse1", {31'h0, collision1}, 32'h1);
    idle();
    step();
    check("coll_end0", {31'h0, collision0}, 32'h0);
    check("coll_end1", {31'h0, collision1}, 32'h0);
    port_a(1'b1, 1'b0, 8'h20, 32'h0, 4'h0);
    port_b(1'b1, 1'b0, 8'h20, 32'h0, 4'h0);
    step();
    check("coll_word_a0", a_data_out0, 32'h99661155);
    check("coll_word_b0", b_data_out0, 32'h99661155);
    idle();
    step();
    check("coll_word_a1", a_data_out1, 32'h99661155);
    check("coll_word_b1", b_data_out1, 32'h99661155);

    // Cross-port read during write
    port_a(1'b1, 1'b1, 8'h40, 32'h00000001, 4'hF);
    step();
    port_a(1'b1, 1'b1, 8'h40, 32'h0000FF02, 4'b0001);
    port_b(1'b1, 1'b0, 8'h40, 32'h0, 4'h0);
    step();
    check("rdw_old0", b_data_out0, 32'h00000001);
    check("rdw_valid0", {31'h0, b_valid0}, 32'h1);
    check("rdw_nocoll0", {31'h0, collision0}, 32'h0);
    check("rdw_nocoll1", {31'h0, collision1}, 32'h0);
    idle();
    step();
    check("rdw_new1", b_data_out1, 32'h00000002);
    check("rdw_valid1", {31'h0, b_valid1}, 32'h1);

    // Address range: 199 is the top word of dut0, 200 and 250 are out of range there
    port_a(1'b1, 1'b1, 8'd199, 32'hC0FFEE00, 4'hF);
    step();
    port_a(1'b1, 1'b1, 8'd250, 32'h12345678, 4'hF);
    port_b(1'b1, 1'b1, 8'd200, 32'hDEADBEEF, 4'hF);
    step();
    check("oor_wr_err0", {30'h0, addr_err0}, 32'h3);
    check("oor_wr_err1", {30'h0, addr_err1}, 32'h0);
    port_a(1'b1, 1'b0, 8'd250, 32'h0, 4'h0);
    port_b(1'b1, 1'b0, 8'd200, 32'h0, 4'h0);
    step();
    check("oor_rd_a0", {a_data_out0[30:0], a_valid0}, 32'h1);
    check("oor_rd_b0", {b_data_out0[30:0], b_valid0}, 32'h1);
    check("oor_rd_err0", {30'h0, addr_err0}, 32'h3);
    port_a(1'b1, 1'b0, 8'd199, 32'h0, 4'h0);
    port_b(1'b1, 1'b0, 8'h10, 32'h0, 4'h0);
    step();
    check("top_word0", a_data_out0, 32'hC0FFEE00);
    check("intact_10_0", b_data_out0, 32'h000000A5);
    check("err_clear0", {30'h0, addr_err0}, 32'h0);
    check("hi_word_a1", a_data_out1, 32'h12345678);
    check("hi_word_b1", b_data_out1, 32'hDEADBEEF);
    idle();
    step();
    check("top_word1", a_data_out1, 32'hC0FFEE00);
    check("intact_10_1", b_data_out1, 32'h000000A5);

    // Reset while reads are in flight
    port_a(1'b1, 1'b0, 8'd1, 32'h0, 4'h0);
    step();
    port_a(1'b1, 1'b0, 8'd2, 32'h0, 4'h0);
    step();
    port_a(1'b1, 1'b0, 8'd3, 32'h0, 4'h0);
    step();
    idle();
    check("inflight_valid1", {31'h0, a_valid1}, 32'h1);
    #4;
    reset_n = 1'b0;
    #1;
    check("midrst_valid1", {31'h0, a_valid1}, 32'h0);
    check("midrst_data1", a_data_out1, 32'h0);
    check("midrst_valid0", {31'h0, a_valid0}, 32'h0);
    step();
    reset_n = 1'b1;
    step();
    check("post_rst_valid1_a", {31'h0, a_valid1}, 32'h0);
    step();
    check("post_rst_valid1_b", {a_data_out1[30:0], a_valid1}, 32'h0);
    check("post_rst_valid0", {31'h0, a_valid0}, 32'h0);
    port_a(1'b1, 1'b0, 8'h10, 32'h0, 4'h0);
    step();
    check("post_rst_rd0", a_data_out0, 32'h000000A5);
    check("post_rst_early1", {31'h0, a_valid1}, 32'h0);
    idle();
    step();
    check("post_rst_rd1", a_data_out1, 32'h000000A5);
    check("post_rst_v1", {31'h0, a_valid1}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
